// File: rtl/power_noise_gen.sv
// power_noise_gen
//   Multi-lane switching-noise generator used to stress power delivery / IR drop
//   in the surrounding logic. LANES independent 32-bit Galois LFSRs are mixed
//   with their neighbour and a constant, gated by a CONTINUOUS/BURST mode, and
//   presented on a registered bus. A saturating counter records how many
//   cycles actually produced noise so that power measurements can be
//   correlated with noise windows.
//
// Ports
//   clk            clock
//   rst_n          asynchronous active-low reset
//   mode           0=OFF, 1=CONTINUOUS, 2=BURST, 3=reserved (acts as OFF)
//   lane_en        per-lane output enable (lanes keep stepping when disabled)
//   seed           seed used by seed_load
//   seed_load      single-cycle pulse: reload all lanes from seed
//   burst_len      ON cycles per burst (0 behaves as 1)
//   idle_len       OFF cycles between bursts (0 = back-to-back bursts)
//   cnt_clr        clears active_cycles
//   noise_bus      registered noise data, 32 bits per lane
//   noise_activity registered XOR-reduction of noise_bus
//   gate_on        registered copy of the internal advance gate
//   active_cycles  saturating count of gated cycles with any lane enabled
module power_noise_gen #(
    parameter int          LANES      = 4,
    parameter logic [31:0] RESET_SEED = 32'h1F2E3D4C,
    parameter logic [31:0] MIX_CONST  = 32'hC3D2E1F0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          mode,
    input  logic [LANES-1:0]    lane_en,
    input  logic [31:0]         seed,
    input  logic                seed_load,
    input  logic [15:0]         burst_len,
    input  logic [15:0]         idle_len,
    input  logic                cnt_clr,
    output logic [32*LANES-1:0] noise_bus,
    output logic                noise_activity,
    output logic                gate_on,
    output logic [31:0]         active_cycles
);

    localparam logic [31:0] LFSR_TAPS = 32'h80200003;
    localparam logic [31:0] LANE_SPREAD = 32'h9E3779B9;

    typedef enum logic [1:0] {ST_IDLE, ST_ON, ST_OFF} state_t;

    // Per-lane seed; an all-zero state would lock the LFSR, so it is replaced.
    function automatic logic [31:0] lane_seed(input logic [31:0] s, input int idx);
        logic [31:0] v;
        v = s ^ (LANE_SPREAD * 32'(idx));
        return (v == 32'h0) ? 32'h0000_0001 : v;
    endfunction

    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        return (x >> 1) ^ (x[0] ? LFSR_TAPS : 32'h0);
    endfunction

    function automatic logic [31:0] rotl16(input logic [31:0] x);
        return {x[15:0], x[31:16]};
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] x);
        return (x == 32'hFFFF_FFFF) ? x : x + 32'h1;
    endfunction

    state_t              state_p0, state_nxt;
    logic [15:0]         cnt_p0, cnt_nxt;
    logic [15:0]         burst_ld;
    logic [31:0]         lane_p0 [LANES];
    logic                gate;
    logic [32*LANES-1:0] bus_nxt;

    // ---- Stage 0: burst FSM, gate and lane state ----
    // Reload value for the ON phase; a zero burst length still yields one cycle.
    assign burst_ld = (burst_len == 16'h0) ? 16'h0 : burst_len - 16'h1;

    always_comb begin
        state_nxt = state_p0;
        cnt_nxt   = cnt_p0;
        if (mode != 2'd2) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = 16'h0;
        end else begin
            case (state_p0)
                ST_IDLE: begin
                    state_nxt = ST_ON;
                    cnt_nxt   = burst_ld;
                end
                ST_ON: begin
                    if (cnt_p0 != 16'h0) begin
                        cnt_nxt = cnt_p0 - 16'h1;
                    end else if (idle_len != 16'h0) begin
                        state_nxt = ST_OFF;
                        cnt_nxt   = idle_len - 16'h1;
                    end else begin
                        state_nxt = ST_ON;
                        cnt_nxt   = burst_ld;
                    end
                end
                ST_OFF: begin
                    if (cnt_p0 != 16'h0) begin
                        cnt_nxt = cnt_p0 - 16'h1;
                    end else begin
                        state_nxt = ST_ON;
                        cnt_nxt   = burst_ld;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = 16'h0;
                end
            endcase
        end
    end

    assign gate = (mode == 2'd1) || ((mode == 2'd2) && (state_p0 == ST_ON));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p0 <= ST_IDLE;
            cnt_p0   <= 16'h0;
        end else begin
            state_p0 <= state_nxt;
            cnt_p0   <= cnt_nxt;
        end
    end

    // Seed reload wins over stepping; lanes advance even when their output is masked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LANES; i++) lane_p0[i] <= lane_seed(RESET_SEED, i);
        end else if (seed_load) begin
            for (int i = 0; i < LANES; i++) lane_p0[i] <= lane_seed(seed, i);
        end else if (gate) begin
            for (int i = 0; i < LANES; i++) lane_p0[i] <= lfsr_step(lane_p0[i]);
        end
    end

    // Neighbour mix uses the current (pre-update) lane values; with one lane
    // the neighbour is the lane itself.
    always_comb begin
        bus_nxt = '0;
        for (int i = 0; i < LANES; i++) begin
            if (gate && lane_en[i]) begin
                bus_nxt[32*i +: 32] = lane_p0[i] ^ rotl16(lane_p0[(i + 1) % LANES]) ^ MIX_CONST;
            end
        end
    end

    // ---- Stage 1: registered outputs ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            noise_bus      <= '0;
            noise_activity <= 1'b0;
            gate_on        <= 1'b0;
            active_cycles  <= 32'h0;
        end else begin
            noise_bus      <= bus_nxt;
            noise_activity <= ^bus_nxt;
            gate_on        <= gate;
            if (cnt_clr) begin
                active_cycles <= 32'h0;
            end else if (gate && (lane_en != '0)) begin
                active_cycles <= sat_inc(active_cycles);
            end
        end
    end

endmodule

// File: tb/tb_power_noise_gen.sv
`timescale 1ns/1ps
module tb_power_noise_gen;

    localparam int          L     = 4;
    localparam logic [31:0] RSEED = 32'h1F2E3D4C;
    localparam logic [31:0] MIXC  = 32'hC3D2E1F0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Four-lane instance
    logic         rst_n;
    logic [1:0]   mode;
    logic [L-1:0] lane_en;
    logic [31:0]  seed;
    logic         seed_load;
    logic [15:0]  burst_len, idle_len;
    logic         cnt_clr;
    logic [127:0] noise_bus;
    logic         noise_activity, gate_on;
    logic [31:0]  active_cycles;

    // Single-lane instance
    logic [1:0]   mode_s;
    logic [0:0]   lane_en_s;
    logic [31:0]  seed_s;
    logic         seed_load_s;
    logic [15:0]  burst_len_s, idle_len_s;
    logic         cnt_clr_s;
    logic [31:0]  noise_bus_s;
    logic         noise_activity_s, gate_on_s;
    logic [31:0]  active_cycles_s;

    power_noise_gen #(.LANES(L)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .lane_en(lane_en), .seed(seed),
        .seed_load(seed_load), .burst_len(burst_len), .idle_len(idle_len),
        .cnt_clr(cnt_clr), .noise_bus(noise_bus), .noise_activity(noise_activity),
        .gate_on(gate_on), .active_cycles(active_cycles)
    );

    power_noise_gen #(.LANES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .mode(mode_s), .lane_en(lane_en_s), .seed(seed_s),
        .seed_load(seed_load_s), .burst_len(burst_len_s), .idle_len(idle_len_s),
        .cnt_clr(cnt_clr_s), .noise_bus(noise_bus_s), .noise_activity(noise_activity_s),
        .gate_on(gate_on_s), .active_cycles(active_cycles_s)
    );

    typedef struct packed {
        logic [127:0] bus;
        logic         act;
        logic         gon;
        logic [31:0]  cnt;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ml [L];
    int          bpos;
    logic [31:0] mcnt;
    int          n_vec = 0;
    int          n_miss = 0;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_seed(input logic [31:0] s, input int idx);
        logic [31:0] acc;
        acc = 32'h0;
        for (int j = 0; j < idx; j++) acc = acc + 32'h9E3779B9;
        acc = s ^ acc;
        if (acc == 32'h0) acc = 32'h1;
        return acc;
    endfunction

    function automatic logic [31:0] m_step(input logic [31:0] x);
        logic [31:0] y;
        y = x >> 1;
        if (x[0]) y = y ^ 32'h80200003;
        return y;
    endfunction

    function automatic logic [31:0] rot16(input logic [31:0] x);
        return {x[15:0], x[31:16]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < L; i++) ml[i] = m_seed(RSEED, i);
        bpos = -1;
        mcnt = 32'h0;
        sb.delete();
    endtask

    // Predict the outputs for the coming edge, advance the model, then compare
    // once the DUT has clocked.
    task automatic run_cycle();
        exp_t e;
        logic g;
        int   bb;
        bb = (burst_len == 16'h0) ? 1 : int'(burst_len);
        g  = (mode == 2'd1) || ((mode == 2'd2) && (bpos >= 0) && (bpos < bb));
        e.bus = '0;
        for (int i = 0; i < L; i++)
            if (g && lane_en[i]) e.bus[32*i +: 32] = ml[i] ^ rot16(ml[(i + 1) % L]) ^ MIXC;
        e.act = ^e.bus;
        e.gon = g;
        if (cnt_clr) e.cnt = 32'h0;
        else if (g && (lane_en != '0) && (mcnt != 32'hFFFFFFFF)) e.cnt = mcnt + 32'h1;
        else e.cnt = mcnt;
        sb.push_back(e);
        mcnt = e.cnt;
        for (int i = 0; i < L; i++) begin
            if (seed_load) ml[i] = m_seed(seed, i);
            else if (g) ml[i] = m_step(ml[i]);
        end
        if (mode != 2'd2) bpos = -1;
        else if (bpos < 0) bpos = 0;
        else bpos = (bpos + 1) % (bb + int'(idle_len));

        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check_val("scoreboard_empty", 128'd0, 128'd1);
        end else begin
            e = sb.pop_front();
            check_val("noise_bus", noise_bus, e.bus);
            check_val("noise_activity", 128'(noise_activity), 128'(e.act));
            check_val("gate_on", 128'(gate_on), 128'(e.gon));
            check_val("active_cycles", 128'(active_cycles), 128'(e.cnt));
            check_val("parity", 128'(noise_activity), 128'(^noise_bus));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_bus"}, noise_bus, 128'd0);
        check_val({tag, "_act"}, 128'(noise_activity), 128'd0);
        check_val({tag, "_gate"}, 128'(gate_on), 128'd0);
        check_val({tag, "_cnt"}, 128'(active_cycles), 128'd0);
        check_val({tag, "_l1_bus"}, 128'(noise_bus_s), 128'd0);
    endtask

    initial begin
        rst_n = 1'b0; mode = 2'd0; lane_en = 4'hF; seed = 32'h0; seed_load = 1'b0;
        burst_len = 16'd0; idle_len = 16'd0; cnt_clr = 1'b0;
        mode_s = 2'd0; lane_en_s = 1'b1; seed_s = 32'h0; seed_load_s = 1'b0;
        burst_len_s = 16'd0; idle_len_s = 16'd0; cnt_clr_s = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Idle with lanes held; single-lane seed reload test runs alongside.
        mode_s = 2'd1; seed_s = 32'h0; seed_load_s = 1'b1;
        for (int c = 0; c < 20; c++) begin
            run_cycle();
            if (c == 0) begin
                check_val("l1_mix_reset_lane", 128'(noise_bus_s), 128'(32'hE1B0C392));
                seed_load_s = 1'b0;
            end else if (c == 1) begin
                check_val("l1_seed0_noStep", 128'(noise_bus_s), 128'(32'hC3D3E1F1));
                check_val("l1_gate", 128'(gate_on_s), 128'd1);
            end else if (c == 2) begin
                check_val("l1_first_step", 128'(noise_bus_s), 128'(32'h43F161D3));
                mode_s = 2'd0;
            end
        end

        // Continuous mode, two lanes masked, one mid-run reseed.
        mode = 2'd1; lane_en = 4'b0101;
        for (int c = 0; c < 100; c++) begin
            seed_load = (c == 50);
            seed      = 32'h12345678;
            run_cycle();
        end
        seed_load = 1'b0;
        check_val("cont_active_100", 128'(active_cycles), 128'd100);

        // Burst 3 on / 2 off.
        mode = 2'd0; cnt_clr = 1'b1; lane_en = 4'hF;
        run_cycle();
        cnt_clr = 1'b0; mode = 2'd2; burst_len = 16'd3; idle_len = 16'd2;
        repeat (20) run_cycle();
        check_val("burst_active_12", 128'(active_cycles), 128'd12);

        // Zero lengths give a continuous gate.
        mode = 2'd0;
        run_cycle();
        mode = 2'd2; burst_len = 16'd0; idle_len = 16'd0;
        repeat (15) run_cycle();
        check_val("burst_zero_gate", 128'(gate_on), 128'd1);

        // Saturation and clear priority.
        mode = 2'd1;
        run_cycle();
        force dut.active_cycles = 32'hFFFFFFFE;
        #1;
        release dut.active_cycles;
        mcnt = 32'hFFFFFFFE;
        repeat (3) run_cycle();
        check_val("sat_hold", 128'(active_cycles), 128'(32'hFFFFFFFF));
        cnt_clr = 1'b1;
        run_cycle();
        check_val("clr_with_gate", 128'(active_cycles), 128'd0);
        cnt_clr = 1'b0;

        // Asynchronous reset inside an ON phase, then a fresh burst.
        mode = 2'd0;
        run_cycle();
        mode = 2'd2; burst_len = 16'd5; idle_len = 16'd3;
        repeat (3) run_cycle();
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) run_cycle();
        check_val("post_reset_active_8", 128'(active_cycles), 128'd8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
